// File: rtl/cp_inserter_if.sv
// cp_inserter_if: sample stream, frame control and framing flags of the CP inserter
interface cp_if #(
    parameter int DW  = 8,
    parameter int CLW = 8
);
    logic [CLW-1:0] cp_len;
    logic           sync_en;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  data_in;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  data_out;
    logic           out_sof;
    logic           out_eof;

    modport slave (
        input  cp_len, sync_en, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, out_sof, out_eof
    );

    modport master (
        output cp_len, sync_en, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, out_sof, out_eof
    );
endinterface

// File: rtl/cp_inserter.sv
// cp_inserter: ping-pong buffered cyclic-prefix and sync-preamble inserter
module cp_inserter #(
    parameter int                  DW        = 8,
    parameter int                  N         = 512,
    parameter int                  CP_MAX    = 128,
    parameter int                  SYNC_LEN  = 13,
    parameter logic [SYNC_LEN-1:0] SYNC_CODE = 13'b1111100110101,
    parameter logic [DW-1:0]       SYNC_HI   = 8'hFF,
    parameter logic [DW-1:0]       SYNC_LO   = 8'h00
) (
    input logic clk,
    input logic reset,
    cp_if.slave bus
);
    localparam int AW  = $clog2(N);
    localparam int CLW = $clog2(CP_MAX + 1);
    localparam int CW  = $clog2((N > SYNC_LEN ? N : SYNC_LEN) + 1);
    localparam int SW  = SYNC_LEN > 1 ? $clog2(SYNC_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CP, S_BODY} state_t;

    logic [DW-1:0]  r_mem [2][N];
    logic [1:0]     r_full;
    logic           r_wb;
    logic           r_rb;
    logic [AW-1:0]  r_wcnt;
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [CLW-1:0] r_cl;
    logic           r_se;
    logic           r_ov;
    logic [DW-1:0]  r_do;
    logic           r_sof;
    logic           r_eof;

    state_t         w_state_nx;
    state_t         w_st;
    state_t         w_first;
    logic [CW-1:0]  w_cnt;
    logic [CW-1:0]  w_cnt_nx;
    logic [CLW-1:0] w_cl;
    logic [CLW-1:0] w_cl_new;
    logic [CLW-1:0] w_cl_nx;
    logic           w_se;
    logic           w_se_nx;
    logic           w_idle;
    logic           w_wr;
    logic           w_ld;
    logic           w_act;
    logic           w_fire;
    logic           w_last;
    logic           w_rel;
    logic           w_chain;
    logic           w_sof;
    logic           w_eof;
    logic [AW-1:0]  w_addr;
    logic [SW-1:0]  w_sidx;
    logic [DW-1:0]  w_data;

    function automatic state_t first_state(input logic se, input logic [CLW-1:0] cl);
        return se ? S_SYNC : (cl != '0) ? S_CP : S_BODY;
    endfunction

    assign bus.in_ready  = !r_full[r_wb];
    assign bus.out_valid = r_ov;
    assign bus.data_out  = r_do;
    assign bus.out_sof   = r_sof;
    assign bus.out_eof   = r_eof;

    assign w_wr     = bus.in_valid && !r_full[r_wb];
    assign w_ld     = !r_ov || bus.out_ready;
    assign w_cl_new = (bus.cp_len > CLW'(CP_MAX)) ? CLW'(CP_MAX) : bus.cp_len;

    // In IDLE the first beat of a ready bank is issued straight from the live cp_len/sync_en
    // so the frame starts one edge after the bank fills; CP reads wrap modulo N.
    always_comb begin
        w_idle     = r_state == S_IDLE;
        w_cl       = w_idle ? w_cl_new : r_cl;
        w_se       = w_idle ? bus.sync_en : r_se;
        w_first    = first_state(w_se, w_cl);
        w_st       = w_idle ? w_first : r_state;
        w_cnt      = w_idle ? '0 : r_cnt;
        w_act      = !w_idle || r_full[r_rb];
        w_fire     = w_act && w_ld;
        w_addr     = (w_st == S_CP) ? AW'(w_cnt) - AW'(w_cl) : AW'(w_cnt);
        w_sidx     = SW'(SYNC_LEN - 1) - SW'(w_cnt);
        w_data     = (w_st == S_SYNC) ? (SYNC_CODE[w_sidx] ? SYNC_HI : SYNC_LO) : r_mem[r_rb][w_addr];
        w_sof      = w_cnt == '0 && w_st == w_first;
        w_eof      = w_st == S_BODY && w_cnt == CW'(N - 1);
        w_last     = (w_st == S_SYNC) ? w_cnt == CW'(SYNC_LEN - 1) :
                     (w_st == S_CP)   ? w_cnt == CW'(w_cl) - CW'(1) : w_eof;
        w_rel      = w_fire && w_eof;
        w_chain    = w_rel && r_full[~r_rb];
        w_state_nx = !w_fire ? r_state :
                     !w_last ? w_st :
                     (w_st == S_SYNC) ? ((w_cl != '0) ? S_CP : S_BODY) :
                     (w_st == S_CP)   ? S_BODY :
                     w_chain ? first_state(bus.sync_en, w_cl_new) : S_IDLE;
        w_cnt_nx   = !w_fire ? r_cnt : w_last ? '0 : w_cnt + 1'b1;
        w_cl_nx    = w_chain ? w_cl_new : w_fire ? w_cl : r_cl;
        w_se_nx    = w_chain ? bus.sync_en : w_fire ? w_se : r_se;
    end

    // Read FSM state, position within the current section and the per-frame settings
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cl    <= '0;
            r_se    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cl    <= w_cl_nx;
            r_se    <= w_se_nx;
        end
    end

    // Sample storage; a full bank is never written because in_ready gates the write
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wb][r_wcnt] <= bus.data_in;
    end

    // Bank ownership: the writer fills and hands over banks, the reader releases them after sample N-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= '0;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_wcnt <= '0;
        end else begin
            if (w_wr) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == AW'(N - 1)) begin
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                end
            end
            if (w_rel) begin
                r_full[r_rb] <= 1'b0;
                r_rb         <= ~r_rb;
            end
        end
    end

    // Output register; everything holds while a beat is presented and not taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ov  <= 1'b0;
            r_do  <= '0;
            r_sof <= 1'b0;
            r_eof <= 1'b0;
        end else if (w_ld) begin
            r_ov  <= w_act;
            r_do  <= w_act ? w_data : r_do;
            r_sof <= w_fire && w_sof;
            r_eof <= w_fire && w_eof;
        end
    end
endmodule

// File: doc/cp_inserter.md
# cp_inserter

Parametrised cyclic-prefix inserter for the VLC U-OFDM transmit chain. It sits between the IFFT output and the DAC/LED driver. It buffers complete IFFT symbols in a ping-pong memory and emits each one as: optional Barker sync preamble, then a runtime-selectable cyclic prefix, then the symbol body. Compared with the fixed single-buffer CP stage, it runs in one clock domain, uses valid/ready handshakes on both sides, and sustains back-to-back symbols with no idle gap.

## Interface
- DW, 8, sample width in bits
- N, 512, IFFT symbol length in samples; must be a power of two, at least 8
- CP_MAX, 128, largest cyclic prefix allowed; must be at most N
- SYNC_LEN, 13, preamble length in samples
- SYNC_CODE, 13'b1111100110101, preamble bit pattern, sent MSB first
- SYNC_HI, 8'hFF, sample value emitted for a preamble bit of 1
- SYNC_LO, 8'h00, sample value emitted for a preamble bit of 0
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- cp_len  in  $clog2(CP_MAX+1)  CP length; sampled at the start of each output frame
- sync_en  in  1  when 1, the frame is prefixed with the preamble; sampled at frame start
- in_valid  in  1  data_in holds a valid sample
- in_ready  out  1  block can accept a sample
- data_in  in  DW  IFFT output sample; the first accepted sample of each symbol is index 0
- out_valid  out  1  data_out holds a valid sample
- out_ready  in  1  downstream can accept a sample
- data_out  out  DW  output sample (registered)
- out_sof  out  1  qualifies the first sample of a frame (preamble or CP)
- out_eof  out  1  qualifies sample N-1 of the body

## Operation
- **Buffer.**
  - Two banks of N×DW, with async-read array storage.
  - Each bank has a full flag.
  - The write pointer wb selects the bank being filled; the read pointer rb selects the bank being emitted.
- **Write side.**
  - in_ready = !full[wb].
  - A sample is accepted when in_valid && in_ready. It is written to bank wb at address wcnt, then wcnt increments.
  - When the Nth sample is accepted: wcnt wraps to 0, full[wb] is set, and wb toggles.
- **Read FSM states:** IDLE, SYNC, CP, BODY.
  - **IDLE:** when full[rb]=1, latch cl = min(cp_len, CP_MAX) and se = sync_en. Go to SYNC if se, else CP if cl≠0, else BODY.
  - **SYNC:** emit SYNC_CODE[SYNC_LEN-1-k] mapped to SYNC_HI or SYNC_LO, for k = 0..SYNC_LEN-1.
  - **CP:** emit bank[rb][N-cl+j] for j = 0..cl-1.
  - **BODY:** emit bank[rb][i] for i = 0..N-1.
- **End of BODY.** When sample N-1 is loaded into the output register:
  - clear full[rb] and toggle rb;
  - if the other bank is already full, latch a new cl/se and enter the first state of the next frame directly, with no IDLE cycle;
  - otherwise go to IDLE.
- **Output register.** data_out, out_sof and out_eof load whenever !out_valid || out_ready.
  - out_valid holds while out_ready=0; data_out, out_sof and out_eof stay stable meanwhile.
- **Frame length** = (se ? SYNC_LEN : 0) + cl + N.
- **Clamping.** A cp_len value above CP_MAX is clamped to CP_MAX. cp_len=0 gives no prefix.
- **Simultaneous events.** If a bank is released on the same edge the write side is waiting for it, in_ready rises on the following cycle. The block never writes a full bank.
- **Reset** (asynchronous, including mid-frame):
  - state=IDLE; wb=rb=0; wcnt=0; full flags=0;
  - in_ready=1 after reset deasserts; out_valid=0, data_out=0, out_sof=0, out_eof=0;
  - partially received or emitted symbols are discarded.

## Timing
- **Latency.** The Nth input sample is accepted at edge k. out_valid=1 with the frame's first sample from edge k+1.
- **Throughput.** With out_ready held at 1, one sample is output per cycle, including across frame boundaries.
- **Input stall.** in_ready stays 1 until both banks are full.
- **Output period.** Sustained input must average at most N samples per (frame length) cycles. Otherwise in_ready deasserts and throttles the source.
- out_sof and out_eof are high for exactly one accepted output beat per frame.

## Test plan
- **Basic frame.** N=16, CP_MAX=8, cp_len=4, sync_en=0. Write ramp 0..15 → output 12,13,14,15,0..15. out_sof is on 12 and out_eof is on 15. The first out_valid comes 1 cycle after the 16th accept.
- **Preamble.** Same setup with sync_en=1 → 13 samples FF,FF,FF,FF,FF,00,00,FF,FF,00,FF,00,FF, then the CP and body above. out_sof is on the first FF. Frame length is 33.
- **Clamp and zero.** cp_len=15 → 8 CP samples (8..15). cp_len=0 → body only, with out_sof on sample 0.
- **Back-to-back.** Stream 3 symbols continuously with out_ready=1 → no out_valid gap between frames. in_ready drops while both banks are full and recovers one cycle after each release.
- **Backpressure.** Toggle out_ready randomly → the output sequence is identical to the ready=1 run, and data_out is stable whenever out_valid && !out_ready.
- **Reset mid-frame.** Assert reset during a CP → out_valid=0 and in_ready=1 immediately. The next full symbol is emitted cleanly with out_sof on its first sample.
